datapath_ctrl: RTL and testbench
================================

# datapath_ctrl

Single-issue sequencer for the 16-register datapath. It accepts one 16-bit instruction per valid/ready handshake and holds it on the datapath `Opcode` bus. It gives the ALU a settle cycle, then pulses a one-hot `RegEnable` to write `AluBus` back into the destination register. It also keeps the architectural flag register, which feeds `Cin` for carry-using operations.

## Interface
Parameters:
- `NOP_CODE`, default 8'h00: `{instr[15:12], instr[7:4]}` value for no-operation; no write, no flag update.
- `CMP_CODE`, default 8'hB0: compare; flags update, no register write.
- `C_IDX`, default 0: bit of `Flags` holding carry. Flag order is {N,Z,F,L,C} = bits [4:0].

Ports:
- `Clk` in 1: system clock, rising edge.
- `Reset` in 1: synchronous, active-low reset.
- `instr_in` in 16: instruction `{op[3:0], rA[3:0], ext[3:0], rB[3:0]}`.
- `instr_valid` in 1: `instr_in` is valid.
- `instr_ready` out 1: controller can accept an instruction.
- `Opcode` out 16: registered instruction to the datapath.
- `RegEnable` out 16: one-hot register write enable; bit `rA` during WB only.
- `Cin` out 1: equals `flags_q[C_IDX]`.
- `Flags` in 5: combinational flags from the datapath ALU.
- `AluBus` in 16: datapath result bus.
- `flags_q` out 5: architectural flag register.
- `result` out 16: last written-back or compared `AluBus` value.
- `done` out 1: one-cycle pulse per retired instruction.

## Operation
- Three-state FSM:
  - IDLE: `instr_ready`=1. On `instr_valid`&&`instr_ready`, latch `instr_in` into `Opcode` and go to EXEC. With no valid, stay in IDLE.
  - EXEC: one settle cycle, unconditionally followed by WB. `Opcode` is stable.
  - WB: then go to IDLE.
- WB actions, by decoded class:
  - Normal: `RegEnable` = 1<<`Opcode[11:8]`; `flags_q` <= `Flags`; `result` <= `AluBus`; `done`=1.
  - CMP: `RegEnable`=0; flags and result update; `done`=1.
  - NOP: `RegEnable`=0; no flag or result update; `done`=1.
- `RegEnable` is 0 in every state except WB and never has more than one bit set. A write to r0 is permitted; no special case.
- `Opcode` holds its value after retirement until the next accept.
- `Cin` is registered from `flags_q`, so an instruction sees the carry produced by its predecessor.
- `instr_in` is ignored outside IDLE. Holding `valid` through a busy period is legal; the instruction is accepted on the next IDLE cycle.
- Reset values (`Reset`=0 at an edge): state=IDLE, `Opcode`=0, `RegEnable`=0, `flags_q`=0, `result`=0, `done`=0, `instr_ready`=1 in the following cycle.
- Reset asserted in EXEC or WB aborts the instruction. If the reset edge coincides with the WB edge, the datapath may still write (the bank samples `RegEnable` at the same edge), but `flags_q`/`result`/`done` take their reset values.

## Timing
- Handshake at edge t0 -> EXEC in cycle t0..t1 -> WB in cycle t1..t2. The register bank captures `AluBus` at edge t2, and `flags_q`/`result` update at the same edge t2. `done` is high during t1..t2.
- `instr_ready` returns high in cycle t2..t3. Back-to-back throughput is one instruction per 3 cycles.
- All outputs are registered except `instr_ready`, which is decoded from state. No combinational path runs from `Flags` or `AluBus` to any output.

## Structure
- Shared package/header holds:
  - state encodings IDLE=2'd0, EXEC=2'd1, WB=2'd2;
  - flag bit indices;
  - `NOP_CODE`/`CMP_CODE` defaults;
  - the instruction field slices.
- Sub-module `instr_class_decode`: combinational. Maps `{Opcode[15:12], Opcode[7:4]}` to {writes_reg, writes_flags} and `Opcode[11:8]` to the one-hot enable.
- The top level instantiates it alongside the FSM and registers, and connects to `datapath` port-for-port.

## Test plan
- Reset, then idle: `Reset`=0 for 2 cycles -> all outputs 0, `instr_ready`=1, `RegEnable`=0 for 10 idle cycles.
- ADD r3,r5 with r3=7, r5=9:
  - `RegEnable`=16'h0008 exactly one cycle after EXEC;
  - r3=16 after WB;
  - `result`=16, `done` pulses once.
- Carry chain: first op sets C=1. The next instruction's `Cin`=1 during its EXEC, and `flags_q[0]` is unchanged until that instruction's WB edge.
- CMP and NOP retirement:
  - CMP r2,r2 -> `RegEnable` stays 0, `flags_q[Z]`=1, `done` pulses.
  - NOP -> `flags_q` and `result` unchanged, `done` pulses.
- Back-to-back with `instr_valid` held high: 4 instructions accepted exactly 3 cycles apart, and `instr_in` changes while busy are ignored.
- Reset during EXEC:
  - no `RegEnable` bit asserts and the target register is unchanged;
  - `instr_ready`=1 the cycle after reset deasserts.

Source files
------------

// File: rtl/datapath_ctrl_pkg.sv
// Shared definitions for the datapath sequencer: state encoding, flag bit
// positions, default class codes and instruction field helpers.
package datapath_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    // Flag register layout {N,Z,F,L,C} = bits [4:0]
    localparam int FLAG_W = 5;
    localparam int FLAG_C = 0;
    localparam int FLAG_L = 1;
    localparam int FLAG_F = 2;
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 4;

    // Class codes are {op[3:0], ext[3:0]}
    localparam logic [7:0] NOP_CODE_DEF = 8'h00;
    localparam logic [7:0] CMP_CODE_DEF = 8'hB0;

    // Instruction layout {op[3:0], rA[3:0], ext[3:0], rB[3:0]}
    function automatic logic [3:0] instr_ra(input logic [15:0] instr);
        return instr[11:8];
    endfunction

    function automatic logic [3:0] instr_rb(input logic [15:0] instr);
        return instr[3:0];
    endfunction

    function automatic logic [7:0] instr_class_code(input logic [15:0] instr);
        return {instr[15:12], instr[7:4]};
    endfunction

    function automatic logic [15:0] onehot16(input logic [3:0] idx);
        return 16'h0001 << idx;
    endfunction

endpackage

// File: rtl/datapath_ctrl_instr_class_decode.sv
// Combinational class decoder: tells the sequencer whether the held
// instruction writes a register and/or the flag register, and which
// register-enable bit belongs to its destination.
module instr_class_decode
    import datapath_ctrl_pkg::*;
#(
    parameter logic [7:0] NOP_CODE = NOP_CODE_DEF,
    parameter logic [7:0] CMP_CODE = CMP_CODE_DEF
)(
    input  logic [15:0] opcode,
    output logic        writes_reg,
    output logic        writes_flags,
    output logic [15:0] reg_onehot
);

    logic [7:0] class_code_s;

    // Classify the instruction and form the destination one-hot
    always_comb begin
        class_code_s = instr_class_code(opcode);
        writes_reg   = 1'b0;
        writes_flags = 1'b0;
        if (class_code_s == NOP_CODE) begin
            writes_reg   = 1'b0;
            writes_flags = 1'b0;
        end else if (class_code_s == CMP_CODE) begin
            writes_reg   = 1'b0;
            writes_flags = 1'b1;
        end else begin
            writes_reg   = 1'b1;
            writes_flags = 1'b1;
        end
        // r0 is an ordinary destination, no special casing
        reg_onehot = onehot16(instr_ra(opcode));
    end

endmodule

// File: rtl/datapath_ctrl.sv
// Single-issue sequencer for the 16-register datapath. Accepts one
// instruction per handshake, holds it on Opcode through a settle cycle,
// then pulses a one-hot RegEnable for write-back and updates the flags.
module datapath_ctrl
    import datapath_ctrl_pkg::*;
#(
    parameter logic [7:0] NOP_CODE = NOP_CODE_DEF,
    parameter logic [7:0] CMP_CODE = CMP_CODE_DEF,
    parameter int         C_IDX    = FLAG_C
)(
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] instr_in,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [15:0] Opcode,
    output logic [15:0] RegEnable,
    output logic        Cin,
    input  logic [4:0]  Flags,
    input  logic [15:0] AluBus,
    output logic [4:0]  flags_q,
    output logic [15:0] result,
    output logic        done
);

    state_t      state_r;
    logic        writes_reg_s;
    logic        writes_flags_s;
    logic [15:0] reg_onehot_s;

    // Decode works on the held Opcode, which is stable in EXEC and WB
    instr_class_decode #(
        .NOP_CODE (NOP_CODE),
        .CMP_CODE (CMP_CODE)
    ) u_decode (
        .opcode       (Opcode),
        .writes_reg   (writes_reg_s),
        .writes_flags (writes_flags_s),
        .reg_onehot   (reg_onehot_s)
    );

    // Ready is a pure decode of the state register
    always_comb begin
        if (state_r == IDLE) begin
            instr_ready = 1'b1;
        end else begin
            instr_ready = 1'b0;
        end
    end

    // Sequencer FSM; every datapath-facing output is registered here
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_r   <= IDLE;
            Opcode    <= 16'h0000;
            RegEnable <= 16'h0000;
            Cin       <= 1'b0;
            flags_q   <= 5'b00000;
            result    <= 16'h0000;
            done      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    RegEnable <= 16'h0000;
                    done      <= 1'b0;
                    if (instr_valid) begin
                        Opcode  <= instr_in;
                        state_r <= EXEC;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                EXEC: begin
                    // Enable and done are raised for exactly the WB cycle
                    RegEnable <= writes_reg_s ? reg_onehot_s : 16'h0000;
                    done      <= 1'b1;
                    state_r   <= WB;
                end
                WB: begin
                    RegEnable <= 16'h0000;
                    done      <= 1'b0;
                    // Flags/result land on the same edge the bank captures AluBus;
                    // Cin tracks the stored carry so the next instruction sees it
                    if (writes_flags_s) begin
                        flags_q <= Flags;
                        result  <= AluBus;
                        Cin     <= Flags[C_IDX];
                    end else begin
                        flags_q <= flags_q;
                        result  <= result;
                        Cin     <= Cin;
                    end
                    state_r <= IDLE;
                end
                default: begin
                    RegEnable <= 16'h0000;
                    done      <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_datapath_ctrl.sv
// Bench for datapath_ctrl: a small behavioural datapath (register bank + ALU)
// drives Flags/AluBus, and a scoreboard queue holds hand-computed expected
// write-back results pushed at each accepted handshake.
module tb_datapath_ctrl;

    logic        Clk;
    logic        Reset;
    logic [15:0] instr_in;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] Opcode;
    logic [15:0] RegEnable;
    logic        Cin;
    logic [4:0]  Flags;
    logic [15:0] AluBus;
    logic [4:0]  flags_q;
    logic [15:0] result;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [15:0] ins;
        logic [15:0] regen;
        logic [15:0] res;
        logic [4:0]  flg;
    } sb_t;

    sb_t sb_q[$];

    datapath_ctrl dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .instr_in    (instr_in),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .Opcode      (Opcode),
        .RegEnable   (RegEnable),
        .Cin         (Cin),
        .Flags       (Flags),
        .AluBus      (AluBus),
        .flags_q     (flags_q),
        .result      (result),
        .done        (done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Behavioural datapath: ops 1=ADD, 2=ADC, 3=LDI imm8, 4=LDH imm8<<8, B=SUB/CMP
    logic [15:0] dp_regs [16];
    logic        dp_init;
    logic [15:0] dp_a;
    logic [15:0] dp_b;
    logic [16:0] dp_wide;

    always_comb begin
        dp_a = dp_regs[Opcode[11:8]];
        dp_b = dp_regs[Opcode[3:0]];
        case (Opcode[15:12])
            4'h1:    dp_wide = {1'b0, dp_a} + {1'b0, dp_b};
            4'h2:    dp_wide = {1'b0, dp_a} + {1'b0, dp_b} + {16'h0000, Cin};
            4'h3:    dp_wide = {9'h000, Opcode[7:0]};
            4'h4:    dp_wide = {1'b0, Opcode[7:0], 8'h00};
            4'hB:    dp_wide = {1'b0, dp_a} - {1'b0, dp_b};
            default: dp_wide = 17'h00000;
        endcase
        AluBus = dp_wide[15:0];
        Flags  = {dp_wide[15], (dp_wide[15:0] == 16'h0000), 1'b0, 1'b0, dp_wide[16]};
    end

    always @(posedge Clk) begin
        for (int i = 0; i < 16; i++) begin
            if (dp_init) dp_regs[i] <= 16'h0000;
            else if (RegEnable[i] === 1'b1) dp_regs[i] <= AluBus;
        end
    end

    function automatic sb_t mk(input logic [15:0] ins, input logic [15:0] regen,
                               input logic [15:0] res, input logic [4:0] flg);
        sb_t e;
        e.ins = ins; e.regen = regen; e.res = res; e.flg = flg;
        return e;
    endfunction

    // Stimulus only: handshake one instruction (push expectation on accept),
    // then wait for done. Called and returns on a falling edge.
    task automatic issue(input sb_t e, output bit timeout, output int lat,
                         output logic [15:0] exec_regen, output logic exec_cin,
                         output logic exec_cflag);
        int n;
        timeout = 1'b0; lat = 0; exec_regen = 16'h0000; exec_cin = 1'b0; exec_cflag = 1'b0;
        n = 0;
        while (instr_ready !== 1'b1 && n < 20) begin @(negedge Clk); n++; end
        if (instr_ready !== 1'b1) begin timeout = 1'b1; return; end
        instr_in = e.ins; instr_valid = 1'b1;
        @(posedge Clk);
        sb_q.push_back(e);
        #1;
        instr_valid = 1'b0;
        instr_in    = 16'h37EE;
        @(negedge Clk);
        exec_regen = RegEnable; exec_cin = Cin; exec_cflag = flags_q[0];
        lat = 1;
        while (done !== 1'b1 && lat < 10) begin @(negedge Clk); lat++; end
        if (done !== 1'b1) timeout = 1'b1;
    endtask

    task automatic test_reset();
        Reset = 1'b0; instr_valid = 1'b0; instr_in = 16'h0000; dp_init = 1'b1;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        n_tests++;
        if (Opcode !== 16'h0000 || RegEnable !== 16'h0000 || Cin !== 1'b0 || flags_q !== 5'h00
            || result !== 16'h0000 || done !== 1'b0 || instr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_values: got op=%h en=%h cin=%b fl=%b res=%h done=%b rdy=%b, expected all zero with rdy=1",
                     Opcode, RegEnable, Cin, flags_q, result, done, instr_ready);
        end
        Reset = 1'b1; dp_init = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge Clk);
            n_tests++;
            if (RegEnable !== 16'h0000 || instr_ready !== 1'b1 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_cycle[%0d]: got en=%h rdy=%b done=%b, expected en=0000 rdy=1 done=0",
                         c, RegEnable, instr_ready, done);
            end
        end
    endtask

    task automatic test_add();
        sb_t tbl[3];
        sb_t e;
        bit to; int lat; logic [15:0] er; logic ec, ef;
        tbl[0] = mk(16'h3307, 16'h0008, 16'h0007, 5'b00000);   // LDI r3,7
        tbl[1] = mk(16'h3509, 16'h0020, 16'h0009, 5'b00000);   // LDI r5,9
        tbl[2] = mk(16'h1305, 16'h0008, 16'h0010, 5'b00000);   // ADD r3,r5
        for (int k = 0; k < 3; k++) begin
            issue(tbl[k], to, lat, er, ec, ef);
            n_tests++;
            if (to) begin
                n_fail++; sb_q.delete();
                $display("FAIL add_timeout[%0d]: no retirement seen, expected done within budget", k);
            end else begin
                e = sb_q.pop_front();
                n_tests++;
                if (lat != 2 || er !== 16'h0000 || RegEnable !== e.regen || Opcode !== e.ins) begin
                    n_fail++;
                    $display("FAIL add_wb[%0d]: got lat=%0d exec_en=%h wb_en=%h op=%h, expected lat=2 exec_en=0000 wb_en=%h op=%h",
                             k, lat, er, RegEnable, Opcode, e.regen, e.ins);
                end
                @(negedge Clk);
                n_tests++;
                if (result !== e.res || flags_q !== e.flg || Cin !== e.flg[0] || done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL add_retire[%0d]: got res=%h fl=%b cin=%b done=%b, expected res=%h fl=%b cin=%b done=0",
                             k, result, flags_q, Cin, done, e.res, e.flg, e.flg[0]);
                end
            end
        end
        n_tests++;
        if (dp_regs[3] !== 16'h0010) begin
            n_fail++; $display("FAIL add_r3: got %h, expected 0010", dp_regs[3]);
        end
        @(negedge Clk);
        n_tests++;
        if (done !== 1'b0 || Opcode !== 16'h1305 || RegEnable !== 16'h0000) begin
            n_fail++;
            $display("FAIL add_hold: got done=%b op=%h en=%h, expected done=0 op=1305 en=0000", done, Opcode, RegEnable);
        end
    endtask

    task automatic test_carry_chain();
        sb_t tbl[4];
        sb_t e;
        bit to; int lat; logic [15:0] er; logic ec, ef;
        tbl[0] = mk(16'h3205, 16'h0004, 16'h0005, 5'b00000);   // LDI r2,5
        tbl[1] = mk(16'h41FF, 16'h0002, 16'hFF00, 5'b10000);   // LDH r1,FF
        tbl[2] = mk(16'h1101, 16'h0002, 16'hFE00, 5'b10001);   // ADD r1,r1 -> C=1
        tbl[3] = mk(16'h2200, 16'h0004, 16'h0006, 5'b00000);   // ADC r2,r0 = 5+0+1
        for (int k = 0; k < 4; k++) begin
            issue(tbl[k], to, lat, er, ec, ef);
            n_tests++;
            if (to) begin
                n_fail++; sb_q.delete();
                $display("FAIL carry_timeout[%0d]: no retirement seen, expected done within budget", k);
            end else begin
                e = sb_q.pop_front();
                if (k == 3) begin
                    n_tests++;
                    if (ec !== 1'b1 || ef !== 1'b1 || flags_q[0] !== 1'b1) begin
                        n_fail++;
                        $display("FAIL carry_cin: got exec cin=%b exec C=%b wb C=%b, expected 1 1 1", ec, ef, flags_q[0]);
                    end
                end
                n_tests++;
                if (RegEnable !== e.regen) begin
                    n_fail++;
                    $display("FAIL carry_wb_en[%0d]: got %h, expected %h", k, RegEnable, e.regen);
                end
                @(negedge Clk);
                n_tests++;
                if (result !== e.res || flags_q !== e.flg || Cin !== e.flg[0]) begin
                    n_fail++;
                    $display("FAIL carry_retire[%0d]: got res=%h fl=%b cin=%b, expected res=%h fl=%b cin=%b",
                             k, result, flags_q, Cin, e.res, e.flg, e.flg[0]);
                end
            end
        end
        n_tests++;
        if (dp_regs[2] !== 16'h0006 || dp_regs[1] !== 16'hFE00) begin
            n_fail++; $display("FAIL carry_regs: got r1=%h r2=%h, expected FE00 0006", dp_regs[1], dp_regs[2]);
        end
    endtask

    task automatic test_cmp_nop();
        sb_t tbl[4];
        sb_t e;
        bit to; int lat; logic [15:0] er; logic ec, ef;
        tbl[0] = mk(16'hB202, 16'h0000, 16'h0000, 5'b01000);   // CMP r2,r2 -> Z
        tbl[1] = mk(16'h0A05, 16'h0000, 16'h0000, 5'b01000);   // NOP (rA ignored)
        tbl[2] = mk(16'hB502, 16'h0000, 16'h0003, 5'b00000);   // CMP r5,r2 = 9-6
        tbl[3] = mk(16'h0000, 16'h0000, 16'h0003, 5'b00000);   // NOP keeps 3 / flags
        for (int k = 0; k < 4; k++) begin
            issue(tbl[k], to, lat, er, ec, ef);
            n_tests++;
            if (to) begin
                n_fail++; sb_q.delete();
                $display("FAIL cmpnop_timeout[%0d]: no retirement seen, expected done within budget", k);
            end else begin
                e = sb_q.pop_front();
                n_tests++;
                if (RegEnable !== e.regen || er !== 16'h0000) begin
                    n_fail++;
                    $display("FAIL cmpnop_en[%0d]: got wb=%h exec=%h, expected %h 0000", k, RegEnable, er, e.regen);
                end
                @(negedge Clk);
                n_tests++;
                if (result !== e.res || flags_q !== e.flg || RegEnable !== 16'h0000) begin
                    n_fail++;
                    $display("FAIL cmpnop_retire[%0d]: got res=%h fl=%b en=%h, expected res=%h fl=%b en=0000",
                             k, result, flags_q, RegEnable, e.res, e.flg);
                end
            end
        end
        n_tests++;
        if (dp_regs[2] !== 16'h0006 || dp_regs[5] !== 16'h0009 || dp_regs[10] !== 16'h0000) begin
            n_fail++;
            $display("FAIL cmpnop_regs: got r2=%h r5=%h r10=%h, expected 0006 0009 0000", dp_regs[2], dp_regs[5], dp_regs[10]);
        end
    endtask

    task automatic test_back_to_back();
        sb_t tbl[4];
        sb_t e, pend;
        bit pend_v, will_acc;
        int idx, ndone, cyc;
        int acc_cyc[4];
        tbl[0] = mk(16'h3811, 16'h0100, 16'h0011, 5'b00000);   // LDI r8,11
        tbl[1] = mk(16'h3922, 16'h0200, 16'h0022, 5'b00000);   // LDI r9,22
        tbl[2] = mk(16'h1A08, 16'h0400, 16'h0011, 5'b00000);   // ADD r10,r8
        tbl[3] = mk(16'h1809, 16'h0100, 16'h0033, 5'b00000);   // ADD r8,r9
        idx = 0; ndone = 0; cyc = 0; pend_v = 1'b0; pend = '0;
        for (int i = 0; i < 4; i++) acc_cyc[i] = -100;
        while ((ndone < 4 || pend_v) && cyc < 40) begin
            if (pend_v) begin
                n_tests++;
                if (result !== pend.res || flags_q !== pend.flg) begin
                    n_fail++;
                    $display("FAIL b2b_retire[%0d]: got res=%h fl=%b, expected res=%h fl=%b",
                             ndone - 1, result, flags_q, pend.res, pend.flg);
                end
                pend_v = 1'b0;
            end
            if (done === 1'b1) begin
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    n_tests++;
                    if (RegEnable !== e.regen) begin
                        n_fail++;
                        $display("FAIL b2b_en[%0d]: got %h, expected %h", ndone, RegEnable, e.regen);
                    end
                    pend = e; pend_v = 1'b1;
                end
                ndone++;
            end
            // valid stays high while busy; data during busy cycles is junk
            will_acc = (instr_ready === 1'b1) && (idx < 4);
            if (will_acc) begin
                instr_in = tbl[idx].ins; instr_valid = 1'b1;
            end else if (idx < 4) begin
                instr_in = 16'h37EE; instr_valid = 1'b1;
            end else begin
                instr_in = 16'h37EE; instr_valid = 1'b0;
            end
            @(posedge Clk);
            if (will_acc) begin
                sb_q.push_back(tbl[idx]);
                acc_cyc[idx] = cyc;
                idx++;
            end
            @(negedge Clk);
            cyc++;
        end
        instr_valid = 1'b0;
        n_tests++;
        if (idx != 4 || ndone != 4 || sb_q.size() != 0) begin
            n_fail++; sb_q.delete();
            $display("FAIL b2b_count: got accepted=%0d retired=%0d left=%0d, expected 4 4 0", idx, ndone, sb_q.size());
        end
        for (int i = 1; i < 4; i++) begin
            n_tests++;
            if (acc_cyc[i] - acc_cyc[i-1] != 3) begin
                n_fail++;
                $display("FAIL b2b_spacing[%0d]: got %0d cycles, expected 3", i, acc_cyc[i] - acc_cyc[i-1]);
            end
        end
        n_tests++;
        if (dp_regs[7] !== 16'h0000 || dp_regs[8] !== 16'h0033 || dp_regs[9] !== 16'h0022 || dp_regs[10] !== 16'h0011) begin
            n_fail++;
            $display("FAIL b2b_regs: got r7=%h r8=%h r9=%h r10=%h, expected 0000 0033 0022 0011",
                     dp_regs[7], dp_regs[8], dp_regs[9], dp_regs[10]);
        end
    endtask

    task automatic test_reset_exec();
        int n;
        bit en_seen;
        n = 0;
        while (instr_ready !== 1'b1 && n < 20) begin @(negedge Clk); n++; end
        instr_in = 16'h3355; instr_valid = 1'b1;                // LDI r3,55
        @(posedge Clk);
        #1;
        instr_valid = 1'b0;
        @(negedge Clk);
        n_tests++;
        if (instr_ready !== 1'b0 || Opcode !== 16'h3355) begin
            n_fail++;
            $display("FAIL rst_exec_entry: got rdy=%b op=%h, expected rdy=0 op=3355", instr_ready, Opcode);
        end
        Reset = 1'b0;
        @(negedge Clk);
        n_tests++;
        if (RegEnable !== 16'h0000 || done !== 1'b0 || Opcode !== 16'h0000 || result !== 16'h0000
            || flags_q !== 5'h00 || Cin !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_exec_values: got en=%h done=%b op=%h res=%h fl=%b cin=%b, expected all zero",
                     RegEnable, done, Opcode, result, flags_q, Cin);
        end
        Reset = 1'b1;
        @(negedge Clk);
        n_tests++;
        if (instr_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_exec_ready: got %b, expected 1", instr_ready);
        end
        en_seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (RegEnable !== 16'h0000 || done !== 1'b0) en_seen = 1'b1;
            @(negedge Clk);
        end
        n_tests++;
        if (en_seen || dp_regs[3] !== 16'h0010) begin
            n_fail++;
            $display("FAIL rst_exec_abort: got stray_en=%b r3=%h, expected 0 and 0010", en_seen, dp_regs[3]);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_carry_chain();
        test_cmp_nop();
        test_back_to_back();
        test_reset_exec();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
